conv_window_acc: RTL and testbench
==================================

Name: conv_window_acc

Overview:
- Parametrised streaming window accumulator for the convolution datapath.
- Sits downstream of the CoreFPU multiplier and sums TAPS consecutive fp32 products into one fp32 result through a registered adder tree.
- Write position is an auto-incrementing tap counter; no external select.
- Adds early flush with zero padding, sticky exception flags, a result counter and full throughput (one window per TAPS input cycles, back-to-back).

Parameters:
- TAPS, 8, products per window; power of two, 2..16.
- LVL, clog2(TAPS), derived; number of adder-tree levels; not overridable.
- CNT_W, 16, width of result counter.

Ports:
- clk  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- DI_VALID  input  1  DIN valid this cycle.
- DIN  input  32  fp32 product from multiplier.
- DI_LAST  input  1  closes the current window early; qualified by DI_VALID.
- DOUT  output  32  fp32 window sum.
- DO_VALID  output  1  one-cycle pulse per window result.
- NaN  output  1  window contained a NaN input; valid with DO_VALID.
- INF  output  1  window contained an infinite input and no NaN; valid with DO_VALID.
- OVFL  output  1  result is infinite while no input was infinite or NaN; valid with DO_VALID.
- TAP_IDX  output  clog2(TAPS)  next write slot.
- WIN_CNT  output  CNT_W  number of results emitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset: All of the following clear to 0 at the clock edge where RST=1: DOUT, DO_VALID, NaN, INF, OVFL, TAP_IDX, WIN_CNT, the window buffer, the sticky flags and every pipeline valid bit. RST overrides all other inputs.
- Fill:
  - On an edge with DI_VALID=1, DIN is written to buf[TAP_IDX].
  - Sticky nan_s/inf_s are updated from DIN: NaN = exponent 8'hFF and mantissa nonzero; INF = exponent 8'hFF and mantissa zero.
- Launch condition: DI_VALID=1 and (TAP_IDX==TAPS-1 or DI_LAST=1).
- On launch, at the same edge:
  - Level-0 registers load the full window including the current DIN. Slots above TAP_IDX are forced to 32'h00000000.
  - The window's flags are captured with it.
  - TAP_IDX returns to 0; buffer and sticky flags clear.
- Next window: may start on the very next cycle; no stall, no ready signal.
- DI_LAST when DI_VALID=0: ignored.
- DI_LAST when TAP_IDX==TAPS-1: identical to a normal launch.
- Tree:
  - Level l (1..LVL) adds adjacent pairs of level l-1 using the combinational fp32 adder and registers sums, a valid bit and the flags.
  - Each level advances one edge.
- Latency: if launch happens at edge E, DO_VALID=1 and DOUT/flags are valid for exactly one cycle after edge E+LVL. For TAPS=8 this is 3 edges.
- DOUT: holds its last value when DO_VALID=0.
- Flags:
  - NaN = any input NaN.
  - INF = any input INF and NaN=0.
  - OVFL = (DOUT exponent 8'hFF) and NaN=0 and INF=0.
  - All flags are 0 when DO_VALID=0.
- WIN_CNT increments at the edge that asserts DO_VALID; FFFF wraps to 0000.
- Reset mid-operation: in-flight windows are discarded; no DO_VALID pulse for them.
- Idle: no DI_VALID means no state change except pipeline drain.
- Arithmetic: adder rounding and denormal handling are those of the shared fp32 adder. The tree sum order is fixed pairwise, (0+1)+(2+3)..., and is bit-exactly reproducible.

Decomposition:
- Package conv_pkg:
  - FP_ZERO = 32'h0, FP_EXP_MAX = 8'hFF.
  - fp_is_nan and fp_is_inf functions.
  - clog2 function.
  - Flag struct {nan, inf}.
- Sub-module fp_tree_level:
  - Parameter PAIRS.
  - Instantiates PAIRS adders, registers sums, valid and OR-merged flags.
  - Top generates LVL instances with PAIRS = TAPS>>l.

Test Plan:
- TAPS=8, eight DIN=3F800000 (1.0), consecutive → DOUT=41000000 (8.0); DO_VALID pulses 3 edges after the 8th input; WIN_CNT=1; all flags 0.
- Three DIN=3F800000 with DI_LAST on the 3rd → DOUT=40400000 (3.0); TAP_IDX=0 after launch; next window starts clean.
- Two back-to-back windows: window A all 40000000 (2.0), window B all BF800000 (-1.0), no gaps → DO_VALID pulses in consecutive windows, DOUT=41800000 (16.0) then C1000000 (-8.0); WIN_CNT=2.
- Window containing one 7FC00000 and one 7F800000 → NaN=1, INF=0. Window containing 7F800000 only → INF=1, NaN=0. Eight 7F000000 → OVFL=1, DOUT=7F800000.
- RST=1 for one cycle, one edge after a launch → no DO_VALID follows; TAP_IDX=0, WIN_CNT=0; next full window of 1.0 produces 41000000.
- WIN_CNT preset near wrap via 65536 windows (or forced) → FFFF → 0000 on the next result.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, flag type and fp32 classification helpers
package conv_pkg;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic nan;
        logic inf;
    } flag_t;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (x[30:23] == FP_EXP_MAX) && (x[22:0] == 23'd0);
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_window_acc_fp_tree_level.sv
// rtl/conv_window_acc_fp_tree_level.sv - one registered level of the pairwise fp32 adder tree
module fp_tree_level
    import conv_pkg::*;
#(
    parameter int PAIRS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*PAIRS-1:0][31:0] in_data,
    input  flag_t                   in_flags,
    output logic                    out_valid,
    output logic [PAIRS-1:0][31:0]  out_data,
    output flag_t                   out_flags
);

    logic [PAIRS-1:0][31:0] sums;

    for (genvar p = 0; p < PAIRS; p++) begin : g_add
        fp32_add u_add (
            .a   (in_data[2*p]),
            .b   (in_data[2*p+1]),
            .sum (sums[p])
        );
    end

    // Data only loads with a valid window so the final level holds its value between results
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data      <= sums;
                out_flags.nan <= in_flags.nan;
                out_flags.inf <= in_flags.inf;
            end
        end
    end

endmodule

// File: rtl/fp32_add.sv
// rtl/fp32_add.sv - combinational fp32 adder, round-to-nearest-even, denormals flushed to zero
module fp32_add
    import conv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic              a_big;
    logic              same;
    logic              rnd;
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [26:0]       my_sh;
    logic [26:0]       norm;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic [23:0]       frac_r;
    logic signed [9:0] e;

    always_comb begin
        a_big = (a[30:0] >= b[30:0]);
        x     = a_big ? a : b;
        y     = a_big ? b : a;
        same  = (x[31] == y[31]);
        mx    = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
        my    = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        d     = x[30:23] - y[30:23];

        // Bits shifted out of the smaller operand collapse into the sticky LSB
        if (d > 8'd26) begin
            my_sh = {26'd0, |my};
        end else begin
            my_sh = (my >> d) | {26'd0, |(my & ~({27{1'b1}} << d))};
        end

        s    = same ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});
        e    = signed'({2'b00, x[30:23]});
        lz   = 5'd0;
        norm = s[26:0];
        if (s[27]) begin
            norm = {s[27:2], s[1] | s[0]};
            e    = e + 10'sd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (s[i]) lz = 5'(26 - i);
            end
            norm = s[26:0] << lz;
            e    = e - signed'({5'd0, lz});
        end

        rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
        frac_r = {1'b0, norm[25:3]} + {23'd0, rnd};
        if (frac_r[23]) e = e + 10'sd1;

        if (fp_is_nan(a) || fp_is_nan(b)) begin
            sum = FP_QNAN;
        end else if (fp_is_inf(a) && fp_is_inf(b) && (a[31] != b[31])) begin
            sum = FP_QNAN;
        end else if (fp_is_inf(a)) begin
            sum = a;
        end else if (fp_is_inf(b)) begin
            sum = b;
        end else if ((s == 28'd0) || (e <= 10'sd0)) begin
            sum = {x[31] & same, 31'd0};
        end else if (e >= 10'sd255) begin
            sum = {x[31], FP_EXP_MAX, 23'd0};
        end else begin
            sum = {x[31], e[7:0], frac_r[22:0]};
        end
    end

endmodule

// File: rtl/conv_window_acc.sv
// rtl/conv_window_acc.sv - streaming TAPS-wide fp32 window accumulator with registered adder tree
module conv_window_acc
    import conv_pkg::*;
#(
    parameter int  TAPS  = 8,
    parameter int  CNT_W = 16,
    localparam int LVL   = clog2(TAPS)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             DI_VALID,
    input  logic [31:0]      DIN,
    input  logic             DI_LAST,
    output logic [31:0]      DOUT,
    output logic             DO_VALID,
    output logic             NaN,
    output logic             INF,
    output logic             OVFL,
    output logic [LVL-1:0]   TAP_IDX,
    output logic [CNT_W-1:0] WIN_CNT
);

    logic [TAPS-1:0][31:0] win_buf;
    logic [TAPS-1:0][31:0] l0_data;
    logic [TAPS-2:0][31:0] tree;
    logic                  l0_valid;
    flag_t                 l0_flags;
    flag_t                 sticky;
    flag_t                 din_flags;
    logic [LVL:0]          vld;
    flag_t [LVL:0]         flg;
    logic                  launch;

    assign din_flags.nan = fp_is_nan(DIN);
    assign din_flags.inf = fp_is_inf(DIN);
    assign launch        = DI_VALID && ((TAP_IDX == LVL'(TAPS - 1)) || DI_LAST);

    // Fill the buffer; on launch snapshot the window (current DIN included, upper slots zeroed)
    always_ff @(posedge clk) begin
        if (RST) begin
            win_buf  <= '0;
            sticky   <= '0;
            TAP_IDX  <= '0;
            l0_data  <= '0;
            l0_valid <= 1'b0;
            l0_flags <= '0;
        end else begin
            l0_valid <= launch;
            if (launch) begin
                for (int i = 0; i < TAPS; i++) begin
                    if (LVL'(i) < TAP_IDX)       l0_data[i] <= win_buf[i];
                    else if (LVL'(i) == TAP_IDX) l0_data[i] <= DIN;
                    else                         l0_data[i] <= FP_ZERO;
                end
                l0_flags.nan <= sticky.nan | din_flags.nan;
                l0_flags.inf <= sticky.inf | din_flags.inf;
                win_buf      <= '0;
                sticky       <= '0;
                TAP_IDX      <= '0;
            end else if (DI_VALID) begin
                win_buf[TAP_IDX] <= DIN;
                sticky.nan       <= sticky.nan | din_flags.nan;
                sticky.inf       <= sticky.inf | din_flags.inf;
                TAP_IDX          <= TAP_IDX + 1'b1;
            end
        end
    end

    assign vld[0] = l0_valid;
    assign flg[0] = l0_flags;

    // Levels are packed into tree[] back to back: level l starts at TAPS - 2*(TAPS>>l)
    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
        localparam int P   = TAPS >> l;
        localparam int OFF = TAPS - 2 * P;
        logic [2*P-1:0][31:0] lvl_in;
        if (l == 1) begin : g_first
            assign lvl_in = l0_data;
        end else begin : g_next
            localparam int IN_OFF = TAPS - 4 * P;
            assign lvl_in = tree[IN_OFF + 2*P - 1 : IN_OFF];
        end
        fp_tree_level #(.PAIRS(P)) u_level (
            .clk       (clk),
            .rst       (RST),
            .in_valid  (vld[l-1]),
            .in_data   (lvl_in),
            .in_flags  (flg[l-1]),
            .out_valid (vld[l]),
            .out_data  (tree[OFF + P - 1 : OFF]),
            .out_flags (flg[l])
        );
    end

    assign DOUT     = tree[TAPS-2];
    assign DO_VALID = vld[LVL];
    assign NaN      = DO_VALID & flg[LVL].nan;
    assign INF      = DO_VALID & flg[LVL].inf & ~flg[LVL].nan;
    assign OVFL     = DO_VALID & (DOUT[30:23] == FP_EXP_MAX) & ~flg[LVL].nan & ~flg[LVL].inf;

    always_ff @(posedge clk) begin
        if (RST)             WIN_CNT <= '0;
        else if (vld[LVL-1]) WIN_CNT <= WIN_CNT + 1'b1;
    end

endmodule

// File: tb/tb_conv_window_acc.sv
// tb/tb_conv_window_acc.sv - directed self-checking bench for conv_window_acc
module tb_conv_window_acc;

    localparam int TAPS  = 8;
    localparam int LVL   = 3;
    localparam int CNT_W = 16;

    localparam logic [31:0] ONE    = 32'h3F80_0000;
    localparam logic [31:0] TWO    = 32'h4000_0000;
    localparam logic [31:0] M_ONE  = 32'hBF80_0000;
    localparam logic [31:0] P_INF  = 32'h7F80_0000;
    localparam logic [31:0] Q_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] BIG    = 32'h7F00_0000;

    logic             clk = 1'b0;
    logic             RST;
    logic             DI_VALID;
    logic [31:0]      DIN;
    logic             DI_LAST;
    logic [31:0]      DOUT;
    logic             DO_VALID;
    logic             NaN;
    logic             INF;
    logic             OVFL;
    logic [LVL-1:0]   TAP_IDX;
    logic [CNT_W-1:0] WIN_CNT;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    conv_window_acc #(.TAPS(TAPS), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .RST      (RST),
        .DI_VALID (DI_VALID),
        .DIN      (DIN),
        .DI_LAST  (DI_LAST),
        .DOUT     (DOUT),
        .DO_VALID (DO_VALID),
        .NaN      (NaN),
        .INF      (INF),
        .OVFL     (OVFL),
        .TAP_IDX  (TAP_IDX),
        .WIN_CNT  (WIN_CNT)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        DI_VALID = 1'b1;
        DIN      = d;
        DI_LAST  = last;
        tick();
        DI_VALID = 1'b0;
        DI_LAST  = 1'b0;
        DIN      = 32'h0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (DO_VALID !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; DI_VALID = 1'b0; DI_LAST = 1'b0; DIN = 32'h0;
        tick(); tick();
        RST = 1'b0;
        n_checks++; if (DO_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", DO_VALID); end
        n_checks++; if (DOUT !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 00000000", DOUT); end
        n_checks++; if (TAP_IDX !== 3'd0) begin n_fail++; $display("FAIL reset_tap: got %0d want 0", TAP_IDX); end
        n_checks++; if (WIN_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", WIN_CNT); end
        n_checks++; if ({NaN, INF, OVFL} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {NaN, INF, OVFL}); end
    endtask

    task automatic test_full_window();
        int lat;
        for (int i = 0; i < 7; i++) push(ONE, 1'b0);
        n_checks++; if (TAP_IDX !== 3'd7) begin n_fail++; $display("FAIL full_tap7: got %0d want 7", TAP_IDX); end
        push(ONE, 1'b0);
        n_checks++; if (TAP_IDX !== 3'd0) begin n_fail++; $display("FAIL full_tap0: got %0d want 0", TAP_IDX); end
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL full_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if (DOUT !== 32'h4100_0000) begin n_fail++; $display("FAIL full_dout: got %h want 41000000", DOUT); end
        n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL full_cnt: got %0d want %0d", WIN_CNT, exp_cnt); end
        n_checks++; if ({NaN, INF, OVFL} !== 3'b000) begin n_fail++; $display("FAIL full_flags: got %b want 000", {NaN, INF, OVFL}); end
        tick();
        n_checks++; if (DO_VALID !== 1'b0) begin n_fail++; $display("FAIL full_pulse: got %b want 0", DO_VALID); end
        n_checks++; if (DOUT !== 32'h4100_0000) begin n_fail++; $display("FAIL full_hold: got %h want 41000000", DOUT); end
    endtask

    task automatic test_early_flush();
        int lat;
        push(ONE, 1'b0); push(ONE, 1'b0); push(ONE, 1'b1);
        n_checks++; if (TAP_IDX !== 3'd0) begin n_fail++; $display("FAIL flush_tap: got %0d want 0", TAP_IDX); end
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL flush_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if (DOUT !== 32'h4040_0000) begin n_fail++; $display("FAIL flush_dout: got %h want 40400000", DOUT); end
        n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", WIN_CNT, exp_cnt); end
        push(ONE, 1'b0);
        DI_LAST = 1'b1;
        tick();
        DI_LAST = 1'b0;
        n_checks++; if (TAP_IDX !== 3'd1) begin n_fail++; $display("FAIL last_no_valid_tap: got %0d want 1", TAP_IDX); end
        push(ONE, 1'b1);
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL clean_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if (DOUT !== 32'h4000_0000) begin n_fail++; $display("FAIL clean_dout: got %h want 40000000", DOUT); end
        n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL clean_cnt: got %0d want %0d", WIN_CNT, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < 8; i++) push(TWO, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            push(M_ONE, k == 8);
            if (k == 3) begin
                exp_cnt++;
                n_checks++; if (DO_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_a_valid: got %b want 1", DO_VALID); end
                n_checks++; if (DOUT !== 32'h4180_0000) begin n_fail++; $display("FAIL b2b_a_dout: got %h want 41800000", DOUT); end
                n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL b2b_a_cnt: got %0d want %0d", WIN_CNT, exp_cnt); end
            end else begin
                n_checks++; if (DO_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_k%0d: got %b want 0", k, DO_VALID); end
            end
        end
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL b2b_b_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if (DOUT !== 32'hC100_0000) begin n_fail++; $display("FAIL b2b_b_dout: got %h want C1000000", DOUT); end
        n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL b2b_b_cnt: got %0d want %0d", WIN_CNT, exp_cnt); end
    endtask

    task automatic test_flags();
        int lat;
        push(Q_NAN, 1'b0); push(P_INF, 1'b0);
        for (int i = 0; i < 6; i++) push(ONE, 1'b0);
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL nan_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if ({NaN, INF, OVFL} !== 3'b100) begin n_fail++; $display("FAIL nan_flags: got %b want 100", {NaN, INF, OVFL}); end
        push(P_INF, 1'b0);
        for (int i = 0; i < 7; i++) push(ONE, 1'b0);
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if ({NaN, INF, OVFL} !== 3'b010) begin n_fail++; $display("FAIL inf_flags: got %b want 010", {NaN, INF, OVFL}); end
        n_checks++; if (DOUT !== P_INF) begin n_fail++; $display("FAIL inf_dout: got %h want 7F800000", DOUT); end
        for (int i = 0; i < 8; i++) push(BIG, 1'b0);
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if ({NaN, INF, OVFL} !== 3'b001) begin n_fail++; $display("FAIL ovfl_flags: got %b want 001", {NaN, INF, OVFL}); end
        n_checks++; if (DOUT !== P_INF) begin n_fail++; $display("FAIL ovfl_dout: got %h want 7F800000", DOUT); end
        n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL flags_cnt: got %0d want %0d", WIN_CNT, exp_cnt); end
        tick();
        n_checks++; if ({NaN, INF, OVFL} !== 3'b000) begin n_fail++; $display("FAIL flags_idle: got %b want 000", {NaN, INF, OVFL}); end
    endtask

    task automatic test_reset_mid();
        int  lat;
        logic seen;
        for (int i = 0; i < 8; i++) push(ONE, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_cnt = '0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (DO_VALID === 1'b1) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse: got %b want 0", seen); end
        n_checks++; if (TAP_IDX !== 3'd0) begin n_fail++; $display("FAIL rstmid_tap: got %0d want 0", TAP_IDX); end
        n_checks++; if (WIN_CNT !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", WIN_CNT); end
        for (int i = 0; i < 8; i++) push(ONE, 1'b0);
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL rstmid_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if (DOUT !== 32'h4100_0000) begin n_fail++; $display("FAIL rstmid_dout: got %h want 41000000", DOUT); end
        n_checks++; if (WIN_CNT !== exp_cnt) begin n_fail++; $display("FAIL rstmid_cnt1: got %0d want %0d", WIN_CNT, exp_cnt); end
    endtask

    task automatic test_wrap();
        int lat;
        for (int i = 0; i < 65534; i++) push(ONE, 1'b1);
        exp_cnt = exp_cnt + 16'd65534;
        repeat (LVL + 2) tick();
        n_checks++; if (WIN_CNT !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h want FFFF", WIN_CNT); end
        push(32'h4040_0000, 1'b1);
        wait_valid(lat);
        exp_cnt++;
        n_checks++; if (lat != LVL) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", lat, LVL); end
        n_checks++; if (DOUT !== 32'h4040_0000) begin n_fail++; $display("FAIL wrap_dout: got %h want 40400000", DOUT); end
        n_checks++; if (WIN_CNT !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", WIN_CNT); end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_early_flush();
        test_back_to_back();
        test_flags();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
